// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
// Operations: ADD, SUB, AND, OR, XOR, ADC (uses stored carry), SHL, SHR.
// Shifts iterate one bit per cycle. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    operand handshake (i0, i1, op sampled on transfer)
//   i0, i1, op             operands and opcode; i1[SHAMT_W-1:0] is the shift amount
//   flags_clr              synchronous clear of the stored carry flag
//   out_valid / out_ready  result handshake
//   o, carry, overflow,
//   zero, negative         result and its flags, held while out_valid && !out_ready
//   busy                   high while a shift is iterating
module alu_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   i0,
    input  logic [WIDTH-1:0]   i1,
    input  logic [2:0]         op,
    input  logic               flags_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   o,
    output logic               carry,
    output logic               overflow,
    output logic               zero,
    output logic               negative,
    output logic               busy
);

    localparam int unsigned EW  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;

    logic [1:0]         state, state_n;
    logic [WIDTH-1:0]   o_n;
    logic               carry_n, overflow_n, zero_n, negative_n;
    logic               cflag, cflag_n;
    logic [WIDTH-1:0]   sh, sh_n;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic               sh_right, sh_right_n;

    logic               accept_c;
    logic               is_shift_c;
    logic [SHAMT_W-1:0] amt_c;
    logic               adc_cin_c;
    logic [EW-1:0]      sum_c, diff_c;
    logic [WIDTH-1:0]   alu_o_c;
    logic               alu_c_c, alu_v_c;
    logic [WIDTH-1:0]   step_c;
    logic               step_out_c;

    // Accept is only possible when idle, or when the held result leaves this cycle.
    assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept_c  = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_SHIFT);

    assign amt_c      = i1[SHAMT_W-1:0];
    assign is_shift_c = op[2] & op[1];
    assign adc_cin_c  = (op == OP_ADC) ? cflag : 1'b0;
    assign sum_c      = {1'b0, i0} + {1'b0, i1} + {{WIDTH{1'b0}}, adc_cin_c};
    assign diff_c     = {1'b0, i0} - {1'b0, i1};

    // Single-cycle result; shifts by zero fall to the pass-through default.
    always_comb begin
        alu_o_c = i0;
        alu_c_c = 1'b0;
        alu_v_c = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_o_c = sum_c[WIDTH-1:0];
                alu_c_c = sum_c[WIDTH];
                alu_v_c = (i0[MSB] == i1[MSB]) && (sum_c[MSB] != i0[MSB]);
            end
            OP_SUB: begin
                alu_o_c = diff_c[WIDTH-1:0];
                alu_c_c = diff_c[WIDTH];
                alu_v_c = (i0[MSB] != i1[MSB]) && (diff_c[MSB] != i0[MSB]);
            end
            OP_AND: alu_o_c = i0 & i1;
            OP_OR:  alu_o_c = i0 | i1;
            OP_XOR: alu_o_c = i0 ^ i1;
            default: ;
        endcase
    end

    // One-bit shift step of the working register, with the bit that falls out.
    assign step_c     = sh_right ? (sh >> 1) : (sh << 1);
    assign step_out_c = sh_right ? sh[0] : sh[MSB];

    // Next-state and datapath updates.
    always_comb begin
        state_n    = state;
        o_n        = o;
        carry_n    = carry;
        overflow_n = overflow;
        zero_n     = zero;
        negative_n = negative;
        cflag_n    = cflag;
        sh_n       = sh;
        cnt_n      = cnt;
        sh_right_n = sh_right;

        case (state)
            S_IDLE: ;
            S_SHIFT: begin
                sh_n  = step_c;
                cnt_n = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_n    = S_DONE;
                    o_n        = step_c;
                    carry_n    = step_out_c;
                    overflow_n = 1'b0;
                    zero_n     = (step_c == '0);
                    negative_n = step_c[MSB];
                    cflag_n    = step_out_c;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A new operation overrides the IDLE/DONE transition (covers back-to-back).
        if (accept_c) begin
            if (is_shift_c && (amt_c != '0)) begin
                state_n    = S_SHIFT;
                sh_n       = i0;
                cnt_n      = amt_c;
                sh_right_n = op[0];
            end else begin
                state_n    = S_DONE;
                o_n        = alu_o_c;
                carry_n    = alu_c_c;
                overflow_n = alu_v_c;
                zero_n     = (alu_o_c == '0);
                negative_n = alu_o_c[MSB];
                cflag_n    = alu_c_c;
            end
        end

        if (flags_clr) begin
            cflag_n = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            o        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            cflag    <= 1'b0;
            sh       <= '0;
            cnt      <= '0;
            sh_right <= 1'b0;
        end else begin
            state    <= state_n;
            o        <= o_n;
            carry    <= carry_n;
            overflow <= overflow_n;
            zero     <= zero_n;
            negative <= negative_n;
            cflag    <= cflag_n;
            sh       <= sh_n;
            cnt      <= cnt_n;
            sh_right <= sh_right_n;
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the 16-bit combinational ALU. It adds XOR, add-with-carry and iterative logical shifts, plus a stored carry flag for multi-word arithmetic and zero/negative flags. Operands enter and results leave through valid/ready handshakes, so the block drops into the datapath between the operand fetch stage and writeback. It holds one operation in flight.

Parameters:
WIDTH, 16, operand/result width; legal values 4..64.
SHAMT_W, 4, shift-amount width; must equal clog2(WIDTH).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand/op presented.
in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
i0  in  WIDTH  operand A.
i1  in  WIDTH  operand B; bits [SHAMT_W-1:0] give the shift amount for shifts.
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SHL, 111 SHR (logical).
flags_clr  in  1  synchronous clear of the stored carry flag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
o  out  WIDTH  result.
carry  out  1  carry/borrow/shift-out of the result.
overflow  out  1  signed overflow of the result.
zero  out  1  o == 0.
negative  out  1  o[WIDTH-1].
busy  out  1  high while a shift is iterating.

Behaviour:
- Reset (async, rst=1): state IDLE; o=0; carry, overflow, zero, negative and out_valid = 0; stored carry cflag=0; busy=0. in_ready is forced 0 while rst is high. An operation in flight is abandoned and no result is produced.
- FSM states:
  - IDLE: in_ready=1. On accept, a non-shift op, or a shift with amount 0, goes to DONE. A shift with amount n>0 loads a working register with i0 and a counter with n, then goes to SHIFT.
  - SHIFT: busy=1, in_ready=0. Each cycle: shift one bit, capture the bit shifted out into the carry, decrement the counter. When the counter reaches 0, load the outputs and go to DONE.
  - DONE: out_valid=1. o and all flags are held stable until out_ready. in_ready = out_ready.
    - On out_ready without a new accept → IDLE.
    - On out_ready with a simultaneous accept → next operation, as from IDLE (back-to-back).
- Latency, accept at cycle t:
  - non-shift op, or shift by 0: out_valid at t+1.
  - shift by n: out_valid at t+1+n.
  - Sustained throughput is 1 op/cycle for non-shift ops when out_ready is held high.
- Arithmetic: computed at WIDTH+1 bits, unsigned zero-extended.
  - ADD: carry = bit WIDTH. overflow = (i0 MSB == i1 MSB) && (o MSB != i0 MSB).
  - SUB: o = i0 - i1; carry = borrow (1 iff i0 < i1 unsigned). overflow = (i0 MSB != i1 MSB) && (o MSB != i0 MSB).
  - ADC: i0 + i1 + cflag, where cflag is sampled in the accept cycle; carry and overflow as for ADD.
  - AND/OR/XOR: carry = 0, overflow = 0.
  - SHL/SHR: zero fill. carry = last bit shifted out (0 for amount 0). overflow = 0.
- zero and negative always reflect the registered o.
- cflag is written with the result's carry when the result enters DONE (every op; logic ops write 0).
  - flags_clr in the same cycle wins: cflag = 0.
  - The next ADC accepted back-to-back sees the updated cflag.
- Inputs are ignored when in_ready=0. op, i0 and i1 are sampled only in the accept cycle; later changes do not affect a shift in progress.
- out_valid never drops without out_ready. o and the flags do not change while out_valid=1 and out_ready=0.

Test Plan:
1. ADD 0x7FFF+0x0001 → next cycle out_valid=1, o=0x8000, carry=0, overflow=1, negative=1, zero=0.
2. ADD 0xFFFF+0x0001 → o=0x0000, carry=1, zero=1. Then, back-to-back, ADC 0x0001+0x0001 → o=0x0003. Repeat with flags_clr pulsed between them → o=0x0002.
3. SUB 0x0001-0x0002 → o=0xFFFF, carry=1, overflow=0. SUB 0x8000-0x0001 → o=0x7FFF, carry=0, overflow=1.
4. SHL 0x1001 by 4 (accept at t) → busy=1 for cycles t+1..t+4; out_valid at t+5; o=0x0010, carry=1. SHR 0x0005 by 0 → o=0x0005, carry=0, latency 1.
5. Hold out_ready=0 for 5 cycles with a second op pending → o and flags stable, in_ready=0, no accept. Then hold out_ready=1 and stream 8 XOR ops → one result per cycle, all in order and correct.
6. SHR 0xFFFF by 15; assert rst at the 5th SHIFT cycle → out_valid, o and busy go 0 immediately. After release, no stale result appears, and ADC 0x0001+0x0001 → 0x0002 (cflag was reset).
